// File: rtl/alu_result_stage_if.sv
// Bus bundle between the ALU result stage and its neighbours: the upstream offer,
// the downstream memory-stage handshake, the flush input and the fetch redirect.
interface alu_result_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_result;
    logic                      in_result_is_zero;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic                      in_reg_write;
    logic [1:0]                in_branch_type;
    logic [DATA_WIDTH-1:0]     in_branch_target;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_result;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic                      out_reg_write;
    logic                      redirect_valid;
    logic [DATA_WIDTH-1:0]     redirect_pc;

    // master is the pipeline environment, slave is the result stage itself
    modport master (
        output in_valid, in_result, in_result_is_zero, in_rd, in_reg_write,
               in_branch_type, in_branch_target, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_reg_write,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_result, in_result_is_zero, in_rd, in_reg_write,
               in_branch_type, in_branch_target, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_reg_write,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/alu_result_stage.sv
// Execute-to-memory stage: buffers ALU results in a small FIFO and resolves branches
// into a registered one-cycle fetch redirect. ALU_RESULT_STAGE_PERF_EN adds perf counters.
module alu_result_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_stage_if.slave  bus
`ifdef ALU_RESULT_STAGE_PERF_EN
    ,
    output logic [31:0]        perf_taken_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [DATA_WIDTH-1:0]     result_mem [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] rd_mem     [DEPTH];
    logic                      rw_mem     [DEPTH];
    logic                      push;
    logic                      pop;
    logic                      taken;

    assign bus.in_ready      = (count != FULL_CNT);
    assign bus.out_valid     = (count != '0);
    assign bus.out_result    = result_mem[rd_ptr];
    assign bus.out_rd        = rd_mem[rd_ptr];
    assign bus.out_reg_write = rw_mem[rd_ptr];

    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        taken = 1'b0;
        case (bus.in_branch_type)
            2'd1:    taken = bus.in_result_is_zero;
            2'd2:    taken = ~bus.in_result_is_zero;
            2'd3:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Entry array is reset so the stale head reads 0 straight out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                result_mem[i] <= '0;
                rd_mem[i]     <= '0;
                rw_mem[i]     <= 1'b0;
            end
        end else if (push) begin
            result_mem[wr_ptr] <= bus.in_result;
            rd_mem[wr_ptr]     <= bus.in_rd;
            rw_mem[wr_ptr]     <= bus.in_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Only a pushed branch can redirect, so a flushed instruction never does
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
        end else begin
            bus.redirect_valid <= push & taken;
            if (push & taken) bus.redirect_pc <= bus.in_branch_target;
        end
    end

`ifdef ALU_RESULT_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_taken_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (bus.redirect_valid)               perf_taken_cnt <= perf_taken_cnt + 32'd1;
            if (bus.in_valid && !bus.in_ready)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios then random traffic, checked each cycle
// against a queue-based model of the stage's observable behaviour.
module tb_alu_result_stage;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

`ifdef ALU_RESULT_STAGE_PERF_EN
    logic [31:0] perf_taken_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    alu_result_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_RESULT_STAGE_PERF_EN
        ,
        .perf_taken_cnt (perf_taken_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int passed = 0;
    int total  = 0;

    entry_t      q[$];
    logic        exp_rv = 1'b0;
    logic [31:0] exp_pc = '0;
    int unsigned m_taken = 0;
    int unsigned m_stall = 0;
    bit          last_push = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit is_taken(input logic [1:0] bt, input logic z);
        return (bt == 2'd3) || (bt == 2'd1 && z) || (bt == 2'd2 && !z);
    endfunction

    task automatic set_in(input logic v, input logic [31:0] res, input logic z,
                          input logic [4:0] rd, input logic rw,
                          input logic [1:0] bt, input logic [31:0] tgt);
        bus.in_valid          = v;
        bus.in_result         = res;
        bus.in_result_is_zero = z;
        bus.in_rd             = rd;
        bus.in_reg_write      = rw;
        bus.in_branch_type    = bt;
        bus.in_branch_target  = tgt;
    endtask

    // Checks the stage at mid-cycle, then advances the model across the next rising edge
    task automatic cycle();
        int n;
        bit fl, push, pop;
        entry_t e;
        @(negedge clk);
        n = q.size();
        chk("in_ready", bus.in_ready, n != DEPTH);
        chk("out_valid", bus.out_valid, n != 0);
        if (n != 0) begin
            chk("out_result", bus.out_result, q[0].result);
            chk("out_rd", bus.out_rd, q[0].rd);
            chk("out_reg_write", bus.out_reg_write, q[0].rw);
        end
        chk("redirect_valid", bus.redirect_valid, exp_rv);
        chk("redirect_pc", bus.redirect_pc, exp_pc);
`ifdef ALU_RESULT_STAGE_PERF_EN
        chk("perf_taken_cnt", perf_taken_cnt, m_taken);
        chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
        fl   = bus.flush;
        push = bus.in_valid && (n < DEPTH) && !fl;
        pop  = (n > 0) && bus.out_ready && !fl;
        if (exp_rv) m_taken++;
        if (bus.in_valid && n == DEPTH) m_stall++;
        e.result = bus.in_result;
        e.rd     = bus.in_rd;
        e.rw     = bus.in_reg_write;
        if (fl) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        exp_rv = push && is_taken(bus.in_branch_type, bus.in_result_is_zero);
        if (exp_rv) exp_pc = bus.in_branch_target;
        last_push = push;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] res, input logic z, input logic [4:0] rd,
                         input logic rw, input logic [1:0] bt, input logic [31:0] tgt);
        set_in(1'b1, res, z, rd, rw, bt, tgt);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_push) break;
        end
        chk("offer_accepted", last_push, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 2'd0, '0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_result", bus.out_result, 32'h0);
        chk("rst_out_rd", bus.out_rd, 5'h0);
        chk("rst_out_reg_write", bus.out_reg_write, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_redirect_valid", bus.redirect_valid, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // single push, drained immediately
        offer(32'h2A, 1'b0, 5'd5, 1'b1, 2'd0, 32'h0);
        chk("s1_out_result", bus.out_result, 32'h2A);
        idle(2);

        // back-pressure: third entry waits upstream until a slot frees
        bus.out_ready = 1'b0;
        offer(32'h1, 1'b0, 5'd1, 1'b1, 2'd0, 32'h0);
        offer(32'h2, 1'b0, 5'd2, 1'b0, 2'd0, 32'h0);
        set_in(1'b1, 32'h3, 1'b0, 5'd3, 1'b1, 2'd0, 32'h0);
        idle(2);
        chk("full_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        offer(32'h3, 1'b0, 5'd3, 1'b1, 2'd0, 32'h0);
        idle(4);

        // branch taken on zero, then the same branch not taken
        offer(32'h0, 1'b1, 5'd1, 1'b1, 2'd1, 32'h100);
        chk("br_taken_rv", bus.redirect_valid, 1'b1);
        chk("br_taken_pc", bus.redirect_pc, 32'h100);
        idle(1);
        chk("br_pulse_end", bus.redirect_valid, 1'b0);
        offer(32'h7, 1'b0, 5'd1, 1'b1, 2'd1, 32'h200);
        chk("br_not_taken_rv", bus.redirect_valid, 1'b0);
        idle(2);

        // flush with two buffered entries and an unconditional branch incoming
        bus.out_ready = 1'b0;
        offer(32'hA, 1'b0, 5'd10, 1'b1, 2'd0, 32'h0);
        offer(32'hB, 1'b0, 5'd11, 1'b1, 2'd0, 32'h0);
        bus.out_ready = 1'b1;
        set_in(1'b1, 32'hC, 1'b0, 5'd12, 1'b1, 2'd3, 32'h300);
        bus.flush = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        chk("flush_rv", bus.redirect_valid, 1'b0);
        idle(2);

        // asynchronous reset with one entry buffered and a redirect pending
        bus.out_ready = 1'b0;
        offer(32'h55, 1'b0, 5'd7, 1'b1, 2'd3, 32'h400);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_rv", bus.redirect_valid, 1'b0);
        chk("arst_out_result", bus.out_result, 32'h0);
        q.delete();
        exp_rv  = 1'b0;
        exp_pc  = '0;
        m_taken = 0;
        m_stall = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(1);
        offer(32'h2A, 1'b0, 5'd5, 1'b1, 2'd0, 32'h0);
        chk("post_rst_out_rd", bus.out_rd, 5'd5);
        idle(2);

        // three taken branches, then four stalled offers while full, then a flush
        offer(32'h0, 1'b1, 5'd1, 1'b1, 2'd1, 32'h1000);
        offer(32'h9, 1'b0, 5'd1, 1'b1, 2'd2, 32'h2000);
        offer(32'h9, 1'b0, 5'd1, 1'b1, 2'd3, 32'h3000);
        idle(2);
        bus.out_ready = 1'b0;
        offer(32'h11, 1'b0, 5'd2, 1'b1, 2'd0, 32'h0);
        offer(32'h12, 1'b0, 5'd3, 1'b1, 2'd0, 32'h0);
        set_in(1'b1, 32'h13, 1'b0, 5'd4, 1'b1, 2'd0, 32'h0);
        idle(4);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);
`ifdef ALU_RESULT_STAGE_PERF_EN
        chk("perf_taken_total", perf_taken_cnt, 32'd3);
        chk("perf_stall_total", perf_stall_cnt, 32'd4);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   5'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-memory stage directly downstream of the ALU.
- Captures the ALU result, result-is-zero flag and writeback tag into a small FIFO with a valid/ready handshake toward the memory stage.
- Resolves conditional branches from the zero flag and issues a registered one-cycle fetch redirect.
- Supports pipeline flush.

Parameters:
- DATA_WIDTH, 32, width of result and branch target.
- REG_ADDR_WIDTH, 5, destination register index width.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers an instruction this cycle.
- in_ready  out  1  stage accepts; equals (count != DEPTH), combinational from registered count.
- in_result  in  DATA_WIDTH  ALU result.
- in_result_is_zero  in  1  ALU zero flag (1 = result is zero).
- in_rd  in  REG_ADDR_WIDTH  destination register.
- in_reg_write  in  1  writeback enable for this instruction.
- in_branch_type  in  2  0 none, 1 taken-if-zero, 2 taken-if-nonzero, 3 unconditional.
- in_branch_target  in  DATA_WIDTH  redirect address if taken.
- flush  in  1  discard all buffered entries and any incoming instruction.
- out_valid  out  1  head entry is valid (count != 0).
- out_ready  in  1  downstream accepts the head.
- out_result  out  DATA_WIDTH  head result.
- out_rd  out  REG_ADDR_WIDTH  head destination.
- out_reg_write  out  1  head writeback enable.
- redirect_valid  out  1  one-cycle pulse: taken branch resolved.
- redirect_pc  out  DATA_WIDTH  target for redirect_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count, read pointer and write pointer cleared to 0.
  - out_valid=0, redirect_valid=0, redirect_pc=0.
  - out_result, out_rd and out_reg_write read 0 (the entry array is cleared).
  - Reset mid-stream drops all entries; no redirect is emitted after release.
- Push = in_valid & in_ready & !flush. The entry {result, rd, reg_write} is written at the write pointer and the pointer increments modulo DEPTH.
- Pop = out_valid & out_ready & !flush. The read pointer increments modulo DEPTH.
- count changes by +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop. Push and pop together are legal whenever 0 < count < DEPTH.
- Full (count == DEPTH): in_ready=0, so no push occurs; a pop that cycle frees a slot, and in_ready rises the next cycle.
- Empty: out_valid=0, and the out_* data ports hold the stale value at the read pointer.
- Latency: an entry pushed at edge N is visible on out_* after edge N (first cycle N+1). There is no combinational bypass from in_* to out_*.
- Branch taken condition, evaluated only on push:
  - type 1: in_result_is_zero == 1.
  - type 2: in_result_is_zero == 0.
  - type 3: always taken.
  - type 0: never taken.
- On a push with branch taken: redirect_valid=1 and redirect_pc=in_branch_target, both registered at that edge and held for exactly one cycle.
- The branch entry is still enqueued, so a link-register write reaches writeback.
- redirect_pc holds its last value when redirect_valid=0.
- Flush (synchronous, 1 cycle):
  - count and both pointers reset to 0.
  - The incoming instruction is dropped and no redirect is generated for it.
  - A redirect already registered from the previous edge is not cancelled.
  - Flush has priority over push and pop in the same cycle.
- Pointers wrap from DEPTH-1 to 0 with no gap.

Optional Feature:
- Macro ALU_RESULT_STAGE_PERF_EN.
- Defined: adds outputs perf_taken_cnt and perf_stall_cnt, both 32 bits, reset to 0 by rst_n and unaffected by flush.
  - perf_taken_cnt increments on every redirect_valid assertion.
  - perf_stall_cnt increments on every cycle with in_valid=1 and in_ready=0.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Push result 0x0000002A, rd=5, reg_write=1 with out_ready=1 -> out_valid=1 with out_result=0x2A, out_rd=5 on the next cycle, then out_valid=0 on the following cycle.
- Hold out_ready=0 and push 3 entries back-to-back (0x1, 0x2, 0x3) -> in_ready drops after the 2nd push, the 3rd is held upstream. Release out_ready -> outputs appear in order 0x1, 0x2, 0x3 with no loss or duplication.
- Push type 1 with in_result_is_zero=1 and target 0x00000100 -> redirect_valid high for exactly 1 cycle with redirect_pc=0x100. Repeat with zero flag 0 -> redirect_valid stays 0.
- Flush with 2 entries buffered while in_valid=1 carries a type-3 branch -> next cycle out_valid=0, in_ready=1, redirect_valid=0.
- Deassert rst_n asynchronously mid-cycle with 1 entry buffered and a redirect pending -> out_valid and redirect_valid go to 0 immediately. After release, the first push behaves as in the first scenario.
- With ALU_RESULT_STAGE_PERF_EN defined: 3 taken branches plus 4 cycles of in_valid=1 while full -> perf_taken_cnt=3, perf_stall_cnt=4. A flush leaves both counts unchanged.
